// File: rtl/regbank_wb_ctrl.sv
// regbank_wb_ctrl
// Write-port controller and long-latency scoreboard for the 32-entry register bank.
// The ALU and LSU writeback paths share the bank's single write port. The ALU always
// wins, so LSU results wait in a small FIFO. A starvation counter forces a drain
// phase that stalls issue until the FIFO empties. Pending bits for in-flight
// long-latency destinations stall issue on RAW and WAW hazards.
module regbank_wb_ctrl #(
  parameter int size           = 32,
  parameter int mem_depth      = 32,
  parameter int LSU_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ISSUE_VALID,
  input  logic [4:0]           ISSUE_RS1,
  input  logic [4:0]           ISSUE_RS2,
  input  logic [4:0]           ISSUE_RD,
  input  logic                 ISSUE_WE,
  input  logic                 ISSUE_LONG,
  output logic                 issue_stall,
  input  logic                 ALU_WB_VALID,
  input  logic [4:0]           ALU_WB_REG,
  input  logic [size-1:0]      ALU_WB_DATA,
  input  logic                 LSU_WB_VALID,
  input  logic [4:0]           LSU_WB_REG,
  input  logic [size-1:0]      LSU_WB_DATA,
  output logic                 lsu_wb_ready,
  output logic                 ena_write,
  output logic [4:0]           write_reg,
  output logic [size-1:0]      write_data,
  output logic [mem_depth-1:0] pending
);

  localparam int PTR_W = $clog2(LSU_FIFO_DEPTH);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_FIFO_1  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   FIFO_FULL   = (PTR_W + 1)'(LSU_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] STARVE_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] STARVE_MAX  = CNT_W'(STARVE_LIMIT);

  typedef enum logic {NORMAL, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     starve_q, starve_d;

  logic [4:0]           fifo_reg_q  [LSU_FIFO_DEPTH];
  logic [size-1:0]      fifo_data_q [LSU_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]       count_q, count_d;

  logic [mem_depth-1:0] pending_q, pending_d;

  logic                 fifo_empty, fifo_full;
  logic                 push, pop;
  logic                 hz_rs1, hz_rs2, hz_rd;
  logic                 accept, set_long;
  logic                 sel_any;
  logic [4:0]           sel_reg;
  logic [size-1:0]      sel_data;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_FULL);

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign lsu_wb_ready = !RST && !fifo_full;
  assign push         = LSU_WB_VALID && lsu_wb_ready;

  // Register 0 is hardwired, so it can never carry a hazard.
  assign hz_rs1 = (ISSUE_RS1 != 5'd0) && pending_q[ISSUE_RS1];
  assign hz_rs2 = (ISSUE_RS2 != 5'd0) && pending_q[ISSUE_RS2];
  assign hz_rd  = (ISSUE_RD  != 5'd0) && pending_q[ISSUE_RD];

  assign issue_stall = !RST && ISSUE_VALID &&
                       (hz_rs1 || hz_rs2 || (ISSUE_WE && hz_rd) || (state_q == DRAIN));
  assign accept      = !RST && ISSUE_VALID && !issue_stall;
  assign set_long    = accept && ISSUE_WE && ISSUE_LONG && (ISSUE_RD != 5'd0);

  // Write-port mux: the ALU cannot be back-pressured, so it always has priority.
  always_comb begin
    sel_any  = 1'b0;
    sel_reg  = '0;
    sel_data = '0;
    pop      = 1'b0;
    if (!RST) begin
      if (ALU_WB_VALID) begin
        sel_any  = 1'b1;
        sel_reg  = ALU_WB_REG;
        sel_data = ALU_WB_DATA;
      end else if (!fifo_empty) begin
        sel_any  = 1'b1;
        sel_reg  = fifo_reg_q[rd_ptr_q];
        sel_data = fifo_data_q[rd_ptr_q];
        pop      = 1'b1;
      end
    end
  end

  // A reg-0 FIFO head is still popped; only the bank write is suppressed.
  assign ena_write  = sel_any && (sel_reg != 5'd0);
  assign write_reg  = sel_reg;
  assign write_data = sel_data;
  assign pending    = pending_q;

  // Scoreboard update: the clear is applied first so a same-cycle set wins.
  always_comb begin
    pending_d = pending_q;
    if (pop)      pending_d[fifo_reg_q[rd_ptr_q]] = 1'b0;
    if (set_long) pending_d[ISSUE_RD] = 1'b1;
  end

  // Next FIFO occupancy, also used to leave the drain phase on the emptying edge.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_FIFO_1;
    else if (pop && !push) count_d = count_q - CNT_FIFO_1;
  end

  // Starvation FSM next-state: count unserved cycles, drain until the FIFO is empty.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      NORMAL: begin
        if (!fifo_empty && !pop) begin
          if (starve_q == STARVE_LAST) begin
            state_d  = DRAIN;
            starve_d = STARVE_MAX;
          end else begin
            starve_d = starve_q + STARVE_ONE;
          end
        end else begin
          starve_d = '0;
        end
      end
      DRAIN: begin
        if (count_d == '0) begin
          state_d  = NORMAL;
          starve_d = '0;
        end
      end
      default: begin
        state_d  = NORMAL;
        starve_d = '0;
      end
    endcase
  end

  // Starvation FSM state and counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // FIFO pointers, occupancy and scoreboard bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  // FIFO payload storage; contents are meaningless once reset clears the occupancy.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_reg_q[wr_ptr_q]  <= LSU_WB_REG;
      fifo_data_q[wr_ptr_q] <= LSU_WB_DATA;
    end
  end

endmodule

// File: tb/tb_regbank_wb_ctrl.sv
// tb_regbank_wb_ctrl
// Drives directed and random stimulus into regbank_wb_ctrl. A behavioural model
// built on a queue of outstanding LSU results and a pending-register array
// predicts each cycle's outputs and bank writes. A separate monitor pops and
// compares those predictions against what the DUT presents.
module tb_regbank_wb_ctrl;

  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ISSUE_VALID = 1'b0;
  logic [4:0]  ISSUE_RS1 = '0, ISSUE_RS2 = '0, ISSUE_RD = '0;
  logic        ISSUE_WE = 1'b0, ISSUE_LONG = 1'b0;
  logic        issue_stall;
  logic        ALU_WB_VALID = 1'b0;
  logic [4:0]  ALU_WB_REG = '0;
  logic [31:0] ALU_WB_DATA = '0;
  logic        LSU_WB_VALID = 1'b0;
  logic [4:0]  LSU_WB_REG = '0;
  logic [31:0] LSU_WB_DATA = '0;
  logic        lsu_wb_ready;
  logic        ena_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] pending;

  always #5 CLK = ~CLK;

  regbank_wb_ctrl #(
    .size(32), .mem_depth(32), .LSU_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_RS1(ISSUE_RS1), .ISSUE_RS2(ISSUE_RS2),
    .ISSUE_RD(ISSUE_RD), .ISSUE_WE(ISSUE_WE), .ISSUE_LONG(ISSUE_LONG),
    .issue_stall(issue_stall),
    .ALU_WB_VALID(ALU_WB_VALID), .ALU_WB_REG(ALU_WB_REG), .ALU_WB_DATA(ALU_WB_DATA),
    .LSU_WB_VALID(LSU_WB_VALID), .LSU_WB_REG(LSU_WB_REG), .LSU_WB_DATA(LSU_WB_DATA),
    .lsu_wb_ready(lsu_wb_ready),
    .ena_write(ena_write), .write_reg(write_reg), .write_data(write_data),
    .pending(pending)
  );

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic        lng;
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lr;
    logic [31:0] ld;
  } stim_t;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wb_t;

  typedef struct packed {
    logic        stall;
    logic        ready;
    logic        ena;
    logic [31:0] pend;
  } st_t;

  // Reference model state
  wb_t         lsu_m[$];
  logic [31:0] pend_m = '0;
  bit          drain_m = 1'b0;
  int          starve_m = 0;

  // Scoreboard queues
  wb_t exp_wr[$];
  st_t exp_st[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp_v);
    end
  endtask

  // One cycle of the architectural behaviour: outputs seen this cycle, then edge effects.
  task automatic model_step(input stim_t s);
    st_t st;
    wb_t w;
    bit  rdy, acc, was_busy, popped;
    st = '0;
    w  = '0;
    if (s.rst) begin
      st.pend = pend_m;
      exp_st.push_back(st);
      lsu_m.delete();
      pend_m   = '0;
      drain_m  = 1'b0;
      starve_m = 0;
      return;
    end
    rdy      = (lsu_m.size() < DEPTH);
    st.stall = s.iv && (drain_m ||
                        (s.rs1 != 0 && pend_m[s.rs1]) ||
                        (s.rs2 != 0 && pend_m[s.rs2]) ||
                        (s.we && s.rd != 0 && pend_m[s.rd]));
    acc      = s.iv && !st.stall;
    st.ready = rdy;
    st.pend  = pend_m;
    was_busy = (lsu_m.size() != 0);
    popped   = 1'b0;
    if (s.av) begin
      w.r = s.ar;
      w.d = s.ad;
    end else if (was_busy) begin
      w = lsu_m.pop_front();
      popped = 1'b1;
      pend_m[w.r] = 1'b0;
    end
    st.ena = (s.av || was_busy) && (w.r != 0);
    if (st.ena) exp_wr.push_back(w);
    exp_st.push_back(st);
    if (acc && s.we && s.lng && s.rd != 0) pend_m[s.rd] = 1'b1;
    if (s.lv && rdy) lsu_m.push_back({s.lr, s.ld});
    if (!drain_m) begin
      if (was_busy && !popped) begin
        starve_m++;
        if (starve_m == LIMIT) drain_m = 1'b1;
      end else begin
        starve_m = 0;
      end
    end else if (lsu_m.size() == 0) begin
      drain_m  = 1'b0;
      starve_m = 0;
    end
  endtask

  task automatic apply(input stim_t s);
    @(negedge CLK);
    RST          = s.rst;
    ISSUE_VALID  = s.iv;
    ISSUE_RS1    = s.rs1;
    ISSUE_RS2    = s.rs2;
    ISSUE_RD     = s.rd;
    ISSUE_WE     = s.we;
    ISSUE_LONG   = s.lng;
    ALU_WB_VALID = s.av;
    ALU_WB_REG   = s.ar;
    ALU_WB_DATA  = s.ad;
    LSU_WB_VALID = s.lv;
    LSU_WB_REG   = s.lr;
    LSU_WB_DATA  = s.ld;
    model_step(s);
  endtask

  function automatic logic [4:0] rreg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 6));
  endfunction

  // Monitor: compare each cycle's outputs and every bank write against the scoreboard.
  initial begin
    st_t st;
    wb_t w;
    forever begin
      @(negedge CLK);
      #1;
      if (exp_st.size() != 0) begin
        st = exp_st.pop_front();
        chk("issue_stall", 32'(issue_stall), 32'(st.stall));
        chk("lsu_wb_ready", 32'(lsu_wb_ready), 32'(st.ready));
        chk("ena_write", 32'(ena_write), 32'(st.ena));
        chk("pending", pending, st.pend);
        if (ena_write === 1'b1) begin
          if (exp_wr.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL write_unexpected at %0t: reg %0d data 0x%0h, expected no write",
                     $time, write_reg, write_data);
          end else begin
            w = exp_wr.pop_front();
            chk("write_reg", 32'(write_reg), 32'(w.r));
            chk("write_data", write_data, w.d);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    stim_t s;
    stim_t idle;
    int    alu_pct;
    idle = '0;

    // Reset with every input active
    s = idle;
    s.rst = 1; s.iv = 1; s.rs1 = 5; s.rd = 5; s.we = 1; s.lng = 1;
    s.av = 1; s.ar = 3; s.ad = 32'h55; s.lv = 1; s.lr = 4; s.ld = 32'h66;
    apply(s);
    apply(s);
    apply(idle);

    // RAW stall on an in-flight load
    s = idle; s.iv = 1; s.rd = 5; s.we = 1; s.lng = 1; s.rs1 = 1; s.rs2 = 2;
    apply(s);
    s = idle; s.iv = 1; s.rs1 = 5;
    apply(s);
    s.lv = 1; s.lr = 5; s.ld = 32'hDEADBEEF;
    apply(s);
    s.lv = 0;
    apply(s);
    apply(s);
    apply(idle);

    // ALU/LSU collision, order preserved
    s = idle; s.av = 1; s.ar = 3; s.ad = 32'h11; s.lv = 1; s.lr = 7; s.ld = 32'h22;
    apply(s);
    apply(idle);
    apply(idle);

    // Full FIFO while ALU holds the port
    s = idle; s.av = 1; s.ar = 1; s.ad = 32'hA1; s.lv = 1; s.lr = 8; s.ld = 32'h80;
    apply(s);
    s.lr = 9; s.ld = 32'h90;
    apply(s);
    s.lr = 10; s.ld = 32'hA0;
    apply(s);
    s.av = 0;
    apply(s);
    apply(s);
    for (int i = 0; i < 3; i++) apply(idle);

    // Starvation into drain and back
    s = idle; s.av = 1; s.ar = 2; s.ad = 32'h1234; s.lv = 1; s.lr = 12; s.ld = 32'hC0;
    apply(s);
    s.lv = 0; s.iv = 1;
    for (int i = 0; i < 10; i++) begin
      s.ad = 32'(i);
      apply(s);
    end
    s.av = 0;
    apply(s);
    apply(s);
    apply(idle);

    // Register 0 never writes or becomes pending
    s = idle; s.av = 1; s.ar = 0; s.ad = 32'hF0; s.lv = 1; s.lr = 0; s.ld = 32'hF1;
    apply(s);
    apply(idle);
    s = idle; s.iv = 1; s.rd = 0; s.we = 1; s.lng = 1;
    apply(s);
    apply(idle);

    // Random phases alternating light and heavy ALU traffic
    for (int ph = 0; ph < 8; ph++) begin
      alu_pct = (ph % 2 == 1) ? 92 : 40;
      for (int c = 0; c < 400; c++) begin
        s.rst = ($urandom_range(0, 299) == 0);
        s.iv  = ($urandom_range(0, 99) < 70);
        s.rs1 = rreg();
        s.rs2 = rreg();
        s.rd  = rreg();
        s.we  = ($urandom_range(0, 99) < 75);
        s.lng = ($urandom_range(0, 99) < 50);
        s.av  = ($urandom_range(0, 99) < alu_pct);
        s.ar  = rreg();
        s.ad  = $urandom;
        s.lv  = ($urandom_range(0, 99) < 50);
        s.lr  = rreg();
        s.ld  = $urandom;
        apply(s);
      end
    end

    for (int i = 0; i < 4; i++) apply(idle);

    @(negedge CLK);
    #3;
    n_checks++;
    if (exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL writes_outstanding: got %0d, expected 0", exp_wr.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
